// File: rtl/seg7_pkg.sv
// Shared types and constants for the BCD stopwatch and its digit counters.
package seg7_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } sw_state_t;

  localparam bcd_t BCD_MAX = bcd_t'(9);

  // Out-of-range codes fold back to 0 so a digit can never leave 0..9.
  function automatic bcd_t bcd_next(input bcd_t d);
    return (d >= BCD_MAX) ? '0 : d + bcd_t'(1);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One cascadable decade counter; carry fires when it is enabled at 9.
module bcd_digit
  import seg7_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic en,
  output bcd_t q,
  output logic carry
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= bcd_next(q);
    end
  end

  assign carry = en && (q == BCD_MAX);

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit BCD stopwatch (00.00..99.99 s) with debounced start/stop and clear buttons.
module bcd_stopwatch
  import seg7_pkg::*;
#(
  parameter int unsigned DIV     = 500000,
  parameter int unsigned DEB_CYC = 1000000
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY_SS,
  input  logic KEY_CLR,
  output logic [3:0] DIG0,
  output logic [3:0] DIG1,
  output logic [3:0] DIG2,
  output logic [3:0] DIG3,
  output logic RUNNING,
  output logic WRAP
);

  localparam int unsigned PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned LOCK_W = $clog2(DEB_CYC + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(DIV - 1);
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(DEB_CYC - 1);

  // start/stop button conditioning
  logic              ss_s1, ss_s2, ss_prev;
  logic [LOCK_W-1:0] ss_lock;
  logic              ss_acc, ss_go;

  assign ss_acc = ss_prev && !ss_s2 && (ss_lock == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      ss_s1   <= 1'b1;
      ss_s2   <= 1'b1;
      ss_prev <= 1'b1;
      ss_lock <= '0;
      ss_go   <= 1'b0;
    end else begin
      ss_s1   <= KEY_SS;
      ss_s2   <= ss_s1;
      ss_prev <= ss_s2;
      ss_go   <= ss_acc;
      if (ss_acc) begin
        ss_lock <= LOCK_LOAD;
      end else if (ss_lock != '0) begin
        ss_lock <= ss_lock - LOCK_W'(1);
      end
    end
  end

  // clear button conditioning
  logic              clr_s1, clr_s2, clr_prev;
  logic [LOCK_W-1:0] clr_lock;
  logic              clr_acc, clr_go;

  assign clr_acc = clr_prev && !clr_s2 && (clr_lock == '0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      clr_s1   <= 1'b1;
      clr_s2   <= 1'b1;
      clr_prev <= 1'b1;
      clr_lock <= '0;
      clr_go   <= 1'b0;
    end else begin
      clr_s1   <= KEY_CLR;
      clr_s2   <= clr_s1;
      clr_prev <= clr_s2;
      clr_go   <= clr_acc;
      if (clr_acc) begin
        clr_lock <= LOCK_LOAD;
      end else if (clr_lock != '0) begin
        clr_lock <= clr_lock - LOCK_W'(1);
      end
    end
  end

  // run/stop state machine
  sw_state_t state, state_nxt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOP:    if (ss_go) state_nxt = RUN;
      RUN:     if (ss_go) state_nxt = STOP;
      default: state_nxt = STOP;
    endcase
  end

  assign RUNNING = (state == RUN);

  // prescaler holds in STOP so a stop/start keeps the partial tick
  logic [PRE_W-1:0] pre;
  logic             tick;

  assign tick = (state == RUN) && (pre == PRE_LAST);

  always_ff @(posedge CLK) begin
    if (RST || clr_go) begin
      pre <= '0;
    end else if (state == RUN) begin
      pre <= tick ? '0 : pre + PRE_W'(1);
    end
  end

  // decade chain
  bcd_t q0, q1, q2, q3;
  logic c0, c1, c2, c3;

  bcd_digit u_d0 (.CLK(CLK), .RST(RST), .clr(clr_go), .en(tick), .q(q0), .carry(c0));
  bcd_digit u_d1 (.CLK(CLK), .RST(RST), .clr(clr_go), .en(c0),   .q(q1), .carry(c1));
  bcd_digit u_d2 (.CLK(CLK), .RST(RST), .clr(clr_go), .en(c1),   .q(q2), .carry(c2));
  bcd_digit u_d3 (.CLK(CLK), .RST(RST), .clr(clr_go), .en(c2),   .q(q3), .carry(c3));

  assign DIG0 = q0;
  assign DIG1 = q1;
  assign DIG2 = q2;
  assign DIG3 = q3;

  always_ff @(posedge CLK) begin
    if (RST || clr_go) begin
      WRAP <= 1'b0;
    end else begin
      WRAP <= c3;
    end
  end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Scoreboard bench for bcd_stopwatch with DIV=4, DEB_CYC=8.
module tb_bcd_stopwatch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_ss = 1'b1;
  logic       key_clr = 1'b1;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       running, wrap;

  bcd_stopwatch #(.DIV(4), .DEB_CYC(8)) dut (
    .CLK(clk), .RST(rst), .KEY_SS(key_ss), .KEY_CLR(key_clr),
    .DIG0(dig0), .DIG1(dig1), .DIG2(dig2), .DIG3(dig3),
    .RUNNING(running), .WRAP(wrap)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    logic [15:0] dig;
    logic        run;
    logic        wrp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic expect_at(input int unsigned c, input logic [15:0] d,
                           input logic r, input logic w, input string n);
    exp_t e;
    e.cyc = c; e.dig = d; e.run = r; e.wrp = w; e.name = n;
    sb.push_back(e);
  endtask

  task automatic goto(input int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // monitor: every cycle, retire all expectations due now
  initial begin
    forever begin
      @(negedge clk);
      for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          checks++;
          if ({dig3, dig2, dig1, dig0} !== sb[i].dig || running !== sb[i].run || wrap !== sb[i].wrp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got dig=%h running=%b wrap=%b, expected dig=%h running=%b wrap=%b",
                     sb[i].name, cyc, {dig3, dig2, dig1, dig0}, running, wrap,
                     sb[i].dig, sb[i].run, sb[i].wrp);
          end
          sb.delete(i);
        end
      end
    end
  end

  int unsigned c, t0, t1, t2, t3;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    // reset state, then idle
    c = cyc;
    for (int unsigned i = 0; i <= 20; i++) expect_at(c + i, 16'h0000, 1'b0, 1'b0, "idle");
    rst = 1'b0;
    goto(c + 21);

    // first press: start
    c = cyc;
    key_ss = 1'b0;
    expect_at(c + 3, 16'h0000, 1'b0, 1'b0, "start_lat_pre");
    t0 = c + 4;
    expect_at(t0,      16'h0000, 1'b1, 1'b0, "start_lat");
    expect_at(t0 + 3,  16'h0000, 1'b1, 1'b0, "tick_pre");
    expect_at(t0 + 4,  16'h0001, 1'b1, 1'b0, "first_tick");
    expect_at(t0 + 39, 16'h0009, 1'b1, 1'b0, "count9");
    expect_at(t0 + 40, 16'h0010, 1'b1, 1'b0, "carry10");
    goto(c + 2);
    key_ss = 1'b1;
    goto(t0 + 42);

    // second press: stop, frozen with pre=2
    c = cyc;
    key_ss = 1'b0;
    expect_at(c + 3, 16'h0011, 1'b1, 1'b0, "stop_lat_pre");
    for (int unsigned i = 4; i <= 54; i++) expect_at(c + i, 16'h0011, 1'b0, 1'b0, "frozen");
    goto(c + 2);
    key_ss = 1'b1;
    goto(c + 56);

    // third press: resume, partial tick kept
    c = cyc;
    key_ss = 1'b0;
    t1 = c + 4;
    expect_at(c + 3,  16'h0011, 1'b0, 1'b0, "resume_lat_pre");
    expect_at(t1,     16'h0011, 1'b1, 1'b0, "resume");
    expect_at(t1 + 1, 16'h0011, 1'b1, 1'b0, "resume_hold");
    expect_at(t1 + 2, 16'h0012, 1'b1, 1'b0, "kept_partial");
    expect_at(t1 + 6, 16'h0013, 1'b1, 1'b0, "resume_next");
    goto(c + 2);
    key_ss = 1'b1;
    goto(t1 + 8);

    // bounce: low/high/low -> exactly one toggle (stop)
    c = cyc;
    key_ss = 1'b0;
    expect_at(c + 3, 16'h0014, 1'b1, 1'b0, "bounce_pre");
    for (int unsigned i = 4; i <= 20; i++) expect_at(c + i, 16'h0014, 1'b0, 1'b0, "bounce_one");
    goto(c + 2); key_ss = 1'b1;
    goto(c + 4); key_ss = 1'b0;
    goto(c + 5); key_ss = 1'b1;
    goto(c + 22);

    // simultaneous SS+CLR: toggles to RUN and clears
    c = cyc;
    key_ss = 1'b0;
    key_clr = 1'b0;
    expect_at(c + 3, 16'h0014, 1'b0, 1'b0, "ssclr_pre");
    t2 = c + 4;
    expect_at(t2,             16'h0000, 1'b1, 1'b0, "ssclr");
    expect_at(t2 + 4,         16'h0001, 1'b1, 1'b0, "ssclr_tick");
    expect_at(t2 + 4 * 1234,  16'h1234, 1'b1, 1'b0, "mid_1234");
    expect_at(t2 + 39996,     16'h9999, 1'b1, 1'b0, "at_9999");
    expect_at(t2 + 39999,     16'h9999, 1'b1, 1'b0, "pre_wrap");
    expect_at(t2 + 40000,     16'h0000, 1'b1, 1'b1, "wrap");
    expect_at(t2 + 40001,     16'h0000, 1'b1, 1'b0, "wrap_1cyc");
    goto(c + 2);
    key_ss = 1'b1;
    key_clr = 1'b1;

    // clear at 00.37 while running, coinciding with a tick
    goto(t2 + 40148);
    c = cyc;
    key_clr = 1'b0;
    expect_at(c,     16'h0037, 1'b1, 1'b0, "at_0037");
    expect_at(c + 3, 16'h0037, 1'b1, 1'b0, "clr_pre");
    expect_at(c + 4, 16'h0000, 1'b1, 1'b0, "clr_over_tick");
    expect_at(c + 7, 16'h0000, 1'b1, 1'b0, "clr_pre_reset");
    expect_at(c + 8, 16'h0001, 1'b1, 1'b0, "clr_counting");
    goto(c + 2);
    key_clr = 1'b1;
    t3 = c + 4;

    // reset mid-run at 05.12 with pre=2 and a pending SS press
    goto(t3 + 2048);
    key_ss = 1'b0;
    expect_at(t3 + 2048, 16'h0512, 1'b1, 1'b0, "at_0512");
    expect_at(t3 + 2050, 16'h0512, 1'b1, 1'b0, "before_rst");
    for (int unsigned i = 2051; i <= 2072; i++) expect_at(t3 + i, 16'h0000, 1'b0, 1'b0, "after_rst");
    goto(t3 + 2050);
    rst = 1'b1;
    goto(t3 + 2052);
    rst = 1'b0;
    key_ss = 1'b1;
    goto(t3 + 2074);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_stopwatch.md
# bcd_stopwatch

Four-digit BCD stopwatch counter that sits directly upstream of the 7-segment decoders on the board. It has one start/stop button and one clear button. It counts centiseconds from 00.00 to 99.99 s and presents each digit as a 4-bit value on DIG0..DIG3. Each digit drives the 4-bit digit input of its own 7-segment decoder instance (HEX0..HEX3).

## Interface
Parameters:
- DIV, 500000, clock cycles per count tick (50 MHz → 100 Hz); legal range ≥ 2
- DEB_CYC, 1000000, lockout cycles after an accepted button press (20 ms at 50 MHz); legal range ≥ 1

Ports:
- CLK  in  1  system clock; the only clock
- RST  in  1  synchronous, active-high reset
- KEY_SS  in  1  raw start/stop button, active-low, asynchronous to CLK
- KEY_CLR  in  1  raw clear button, active-low, asynchronous to CLK
- DIG0  out  4  BCD hundredths digit, 0–9
- DIG1  out  4  BCD tenths digit, 0–9
- DIG2  out  4  BCD seconds-units digit, 0–9
- DIG3  out  4  BCD seconds-tens digit, 0–9
- RUNNING  out  1  1 while in state RUN
- WRAP  out  1  one-cycle pulse when the count rolls over from 99.99 to 00.00

## Operation
- Input conditioning, per button:
  - 2-FF synchronizer, reset to 1 (released), followed by a previous-value register, also reset to 1.
  - A press is a 1→0 transition at the synchronizer output.
  - A press is accepted only when that button's lockout counter is 0. Acceptance loads the counter with DEB_CYC−1, and it counts down to 0.
  - The two buttons have independent lockout counters.
- State machine: STOP (reset state) and RUN.
  - STOP + accepted SS press → RUN.
  - RUN + accepted SS press → STOP.
  - CLR never changes the state.
- Prescaler `pre`, range 0..DIV−1:
  - Increments only in RUN. Holds its value in STOP, so a stop/start does not lose a partial tick.
  - tick = RUN && pre == DIV−1. On tick, pre → 0.
- Digit chain:
  - On tick, DIG0 increments. A digit at 9 that increments goes to 0 and carries into the next digit.
  - All digits are 9 on tick → all go to 0 and WRAP = 1 for exactly that next cycle.
  - Digits never leave 0–9.
- Accepted CLR press: all digits, pre and WRAP go to 0 on the next edge.
  - CLR has priority over tick in the same cycle.
  - An SS press accepted in the same cycle is still applied, so the state toggles and the count clears.
- RST: every register returns to its reset value regardless of state. This includes a reset in the middle of a lockout or a tick.

## Timing
- Reset values:
  - DIG0..DIG3 = 0, RUNNING = 0, WRAP = 0, pre = 0, lockout counters = 0.
  - Synchronizer and previous-value registers = 1.
- Button latency: KEY falls before edge N and is captured at edge N. The state or clear takes effect at edge N+3, so RUNNING changes in the cycle after edge N+3.
- Count latency: digits update at the edge that ends the tick cycle. In RUN they change every DIV cycles.
- First tick after STOP→RUN from pre = 0 occurs DIV cycles after RUNNING rises.
- WRAP is registered and is high for 1 cycle. It is coincident with DIG* = 0000.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package seg7_pkg holds:
  - BCD_W = 4
  - typedef bcd_t (4-bit)
  - enum sw_state_t {STOP, RUN}
  - constant BCD_MAX = 9
- Sub-module bcd_digit holds one cascadable decade counter:
  - Inputs: CLK, RST, clr, en.
  - Outputs: q (bcd_t) and carry = en && q == 9.
  - Four instances are chained, with each en driven by the previous stage's carry. The first stage's en is tick.
- Button conditioning (synchronizer, edge detect, lockout) stays inline, with two copies.

## Test plan
Run with DIV = 4 and DEB_CYC = 8.
- Reset, then idle 20 cycles → DIG* = 0000, RUNNING = 0, WRAP = 0 throughout.
- KEY_SS low for 2 cycles → RUNNING = 1 three edges after capture; DIG0 = 1 at 4 cycles after RUNNING rises, and DIG1:DIG0 = 10 after 40 cycles.
- Second KEY_SS press after lockout → RUNNING = 0, digits frozen for 50 cycles; third press resumes with no lost partial tick.
- KEY_SS bounces (low / high / low within 5 cycles) → exactly one toggle; the second edge is ignored by the lockout.
- Preload by running to 99.99 → the next tick gives DIG* = 0000 and WRAP = 1 for 1 cycle; then KEY_CLR at 00.37 while running → 00.00, RUNNING stays 1, counting continues.
- RST asserted mid-run (at DIG* = 0512, pre = 2) → next cycle all outputs are at their reset values and a held KEY_SS produces no spurious press.
